rom_memory: RTL and testbench



---
 rtl/rom_memory.sv | 44 ++++
 tb/tb_rom_memory.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rom_memory.sv
// rom_memory: fixed 8-entry constant lookup table with a registered read port.
// The word at ADDR is captured into D_out on every rising clock edge, giving one
// cycle of latency. There is no write port, no enable and no handshake.
module rom_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] D_out
);

  // Table lookup. Addresses beyond the eight defined entries and addresses
  // carrying X/Z fall through to the default arm, so the register never
  // captures an unknown value from the table.
  function automatic logic [DATA_WIDTH-1:0] rom_lookup(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] word;
    word = '0;
    case (a)
      ADDR_WIDTH'(0): word = DATA_WIDTH'(8'h0A);
      ADDR_WIDTH'(1): word = DATA_WIDTH'(8'h1B);
      ADDR_WIDTH'(2): word = DATA_WIDTH'(8'h2C);
      ADDR_WIDTH'(3): word = DATA_WIDTH'(8'h3D);
      ADDR_WIDTH'(4): word = DATA_WIDTH'(8'h4E);
      ADDR_WIDTH'(5): word = DATA_WIDTH'(8'h5F);
      ADDR_WIDTH'(6): word = DATA_WIDTH'(8'h60);
      ADDR_WIDTH'(7): word = DATA_WIDTH'(8'h71);
      default:        word = '0;
    endcase
    return word;
  endfunction

  // Registered read: reset clears the output immediately and discards any
  // pending read; otherwise every edge loads the addressed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_out <= '0;
    end else begin
      D_out <= rom_lookup(ADDR);
    end
  end

endmodule

// File: tb/tb_rom_memory.sv
// tb_rom_memory: self-checking bench for rom_memory.
// Directed vector table, hand-written reset/latency/X sequences, and a random
// address stream checked against an arithmetic model of the table.
`timescale 1ns/100ps
module tb_rom_memory;

  logic       clk;
  logic       rst_n;
  logic [2:0] addr;
  logic [7:0] d_out;

  int n_checks = 0;
  int n_fail   = 0;

  rom_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ADDR  (addr),
    .D_out (d_out)
  );

  // 4 ns clock period
  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Table pattern: high nibble is the address, low nibble is (A + address) mod 16.
  function automatic logic [7:0] model(input logic [2:0] a);
    logic [3:0] hi;
    logic [3:0] lo;
    if ($isunknown(a)) return 8'h00;
    hi = {1'b0, a};
    lo = 4'(4'hA + {1'b0, a});
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: addr=%b d_out=%h at %0t", name, addr, act, $time);
    end
  endtask

  // Drive an address mid-low-phase, take one rising edge, check just after it.
  task automatic step(input logic [2:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    addr = a;
    @(posedge clk);
    #1;
    check(name, d_out, exp);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] held;

    vecs[0]  = '{3'd0, 8'h0A};
    vecs[1]  = '{3'd1, 8'h1B};
    vecs[2]  = '{3'd2, 8'h2C};
    vecs[3]  = '{3'd3, 8'h3D};
    vecs[4]  = '{3'd4, 8'h4E};
    vecs[5]  = '{3'd5, 8'h5F};
    vecs[6]  = '{3'd6, 8'h60};
    vecs[7]  = '{3'd7, 8'h71};
    vecs[8]  = '{3'd7, 8'h71};
    vecs[9]  = '{3'd0, 8'h0A};
    vecs[10] = '{3'd4, 8'h4E};
    vecs[11] = '{3'd1, 8'h1B};

    // Reset held low: clock runs with ADDR=3, output must stay 00.
    rst_n = 1'b0;
    addr  = 3'd3;
    #1;
    check("reset_async_initial", d_out, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", d_out, 8'h00);
    end

    // Release between edges; first edge afterwards loads the table.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Latency: ADDR changes right after the edge, output holds until next edge.
    step(3'd2, 8'h2C, "lat_first");
    addr = 3'd5;
    @(negedge clk);
    #1;
    check("lat_hold", d_out, 8'h2C);
    @(posedge clk);
    #1;
    check("lat_next", d_out, 8'h5F);

    // Asynchronous reset between edges drops the output before the next edge.
    step(3'd3, 8'h3D, "async_pre");
    #0.5;
    rst_n = 1'b0;
    #0.5;
    check("async_drop", d_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 3'd5;
    @(posedge clk);
    #1;
    check("async_release", d_out, 8'h5F);

    // Reset mid-stream for 1.5 cycles, released with ADDR=6.
    step(3'd4, 8'h4E, "mid_pre");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_during", d_out, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    addr  = 3'd6;
    #0.5;
    check("mid_released_no_edge", d_out, 8'h00);
    @(posedge clk);
    #1;
    check("mid_first_edge", d_out, 8'h60);

    // Unknown address, then a normal read.
    @(negedge clk);
    addr = 3'bxxx;
    @(posedge clk);
    #1;
    check("x_addr", d_out, model(addr));
    step(3'd1, 8'h1B, "after_x");

    // Random stream with mid-cycle address wiggle to confirm the output holds.
    for (int i = 0; i < 200; i++) begin
      ra = 3'($urandom_range(0, 7));
      step(ra, model(ra), "rand");
      held = model(ra);
      rb = 3'($urandom_range(0, 7));
      addr = rb;
      #0.5;
      check("rand_hold", d_out, held);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
